// File: rtl/wm_front_panel.sv
// wm_front_panel: synchronises and debounces the panel switches, tracks paid credit and
// sequences start pulse, lid lock and handshake with the controller. Refund path: WM_PANEL_REFUND_EN.
module wm_front_panel #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRICE           = 3,
    parameter int RINSE_PRICE     = 1,
    parameter int CREDIT_MAX      = 15,
    parameter int UNLOCK_DELAY    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_sw,
    input  logic       rinse_btn,
    input  logic       start_btn,
    input  logic       lid_sw,
    input  logic       completed,
`ifdef WM_PANEL_REFUND_EN
    input  logic       refund_btn,
    output logic       refund_pulse,
`endif
    output logic       coin,
    output logic       add_rinse,
    output logic       lid_cl,
    output logic       lid_lock,
    output logic [3:0] credit,
    output logic       rinse_sel,
    output logic       busy,
    output logic       err
);

`ifdef WM_PANEL_REFUND_EN
    localparam int NIN = 5;
`else
    localparam int NIN = 4;
`endif
    // Lid is the top input bit; it is a level, so it gets no edge event.
    localparam int NEV    = NIN - 1;
    localparam int I_COIN = 0;
    localparam int I_RNS  = 1;
    localparam int I_STRT = 2;
    localparam int I_LID  = NIN - 1;

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                DLY_W    = (UNLOCK_DELAY > 2) ? $clog2(UNLOCK_DELAY) : 1;
    localparam logic [DLY_W-1:0]  DLY_LOAD = DLY_W'(UNLOCK_DELAY - 2);
    localparam logic [4:0]        PRICE_C  = 5'(PRICE);
    localparam logic [4:0]        RINSE_C  = 5'(RINSE_PRICE);
    localparam logic [4:0]        MAX_C    = 5'(CREDIT_MAX);

    typedef enum logic [2:0] {S_IDLE, S_START, S_ACK, S_RUN, S_DONE} state_t;

    logic [NIN-1:0]   raw_in, sync1_q, sync2_q, acc_q, acc_d;
    logic [NEV-1:0]   ev_q, ev_d;
    logic [CNT_W-1:0] cnt_q [NIN];
    logic [CNT_W-1:0] cnt_d [NIN];
    state_t           state_q, state_d;
    logic [3:0]       credit_q, credit_d;
    logic             rinse_sel_q, rinse_sel_d, lid_lock_q, lid_lock_d, err_q, err_d;
    logic [1:0]       ack_cnt_q, ack_cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [4:0]       cost, credit_sum;
    logic             launch, ack_fail, excess, refund_busy, refund_dec;
    logic             coin_ev, rinse_ev, start_ev;

`ifdef WM_PANEL_REFUND_EN
    assign raw_in = {lid_sw, refund_btn, start_btn, rinse_btn, coin_sw};
`else
    assign raw_in = {lid_sw, start_btn, rinse_btn, coin_sw};
`endif

    assign coin_ev  = ev_q[I_COIN];
    assign rinse_ev = ev_q[I_RNS];
    assign start_ev = ev_q[I_STRT];

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        acc_d = acc_q;
        ev_d  = '0;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = CNT_LOAD;
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == '0) acc_d[i] = sync2_q[i];
                else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        for (int i = 0; i < NEV; i++) ev_d[i] = acc_d[i] & ~acc_q[i];
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        rinse_sel_d = rinse_sel_q;
        lid_lock_d  = lid_lock_q;
        err_d       = err_q;
        ack_cnt_d   = ack_cnt_q;
        dly_d       = dly_q;
        launch      = 1'b0;
        ack_fail    = 1'b0;
        cost        = PRICE_C + (rinse_sel_q ? RINSE_C : 5'd0);
        unique case (state_q)
            S_IDLE: begin
                if (start_ev && acc_q[I_LID] && ({1'b0, credit_q} >= cost) && !err_q && !refund_busy)
                    state_d = S_START;
                else if (rinse_ev && !start_ev)
                    rinse_sel_d = ~rinse_sel_q;
            end
            S_START: begin
                launch     = 1'b1;
                lid_lock_d = 1'b1;
                ack_cnt_d  = '0;
                state_d    = S_ACK;
            end
            S_ACK: begin
                if (!completed) begin
                    state_d = S_RUN;
                end else if (ack_cnt_q == 2'd3) begin
                    ack_fail   = 1'b1;
                    err_d      = 1'b1;
                    lid_lock_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 2'd1;
                end
            end
            S_RUN: begin
                // Preloaded so lid_lock drops exactly UNLOCK_DELAY cycles after completed rises.
                dly_d = DLY_LOAD;
                if (completed) state_d = S_DONE;
            end
            S_DONE: begin
                if (dly_q == '0) begin
                    lid_lock_d  = 1'b0;
                    rinse_sel_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        credit_sum = {1'b0, credit_q} + {4'b0, coin_ev} + (ack_fail ? cost : 5'd0)
                   - (launch ? cost : 5'd0) - {4'b0, refund_dec};
        excess     = credit_sum > MAX_C;
        credit_d   = excess ? MAX_C[3:0] : credit_sum[3:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            acc_q       <= '0;
            ev_q        <= '0;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= CNT_LOAD;
            state_q     <= S_IDLE;
            credit_q    <= '0;
            rinse_sel_q <= 1'b0;
            lid_lock_q  <= 1'b0;
            err_q       <= 1'b0;
            ack_cnt_q   <= '0;
            dly_q       <= '0;
        end else begin
            sync1_q     <= raw_in;
            sync2_q     <= sync1_q;
            acc_q       <= acc_d;
            ev_q        <= ev_d;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
            state_q     <= state_d;
            credit_q    <= credit_d;
            rinse_sel_q <= rinse_sel_d;
            lid_lock_q  <= lid_lock_d;
            err_q       <= err_d;
            ack_cnt_q   <= ack_cnt_d;
            dly_q       <= dly_d;
        end
    end

`ifdef WM_PANEL_REFUND_EN
    logic       refund_act_q, refund_act_d, refund_pulse_q, refund_pulse_d;
    logic [2:0] gap_q, gap_d;

    // One coin is paid back every eighth cycle until credit reaches zero.
    always_comb begin
        refund_act_d = refund_act_q;
        gap_d        = gap_q;
        refund_dec   = 1'b0;
        if (refund_act_q) begin
            if (gap_q != 3'd0) begin
                gap_d = gap_q - 3'd1;
            end else if (credit_q != 4'd0) begin
                refund_dec = 1'b1;
                gap_d      = 3'd7;
            end else begin
                refund_act_d = 1'b0;
            end
        end else if (ev_q[3] && state_q == S_IDLE) begin
            refund_act_d = 1'b1;
            gap_d        = 3'd0;
        end
        refund_pulse_d = refund_dec | excess;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refund_act_q   <= 1'b0;
            refund_pulse_q <= 1'b0;
            gap_q          <= '0;
        end else begin
            refund_act_q   <= refund_act_d;
            refund_pulse_q <= refund_pulse_d;
            gap_q          <= gap_d;
        end
    end

    assign refund_busy  = refund_act_q;
    assign refund_pulse = refund_pulse_q;
`else
    assign refund_busy = 1'b0;
    assign refund_dec  = 1'b0;
`endif

    assign coin      = (state_q == S_START);
    assign add_rinse = rinse_sel_q & (state_q inside {S_START, S_ACK, S_RUN});
    assign busy      = (state_q inside {S_START, S_RUN, S_DONE});
    assign lid_cl    = acc_q[I_LID];
    assign lid_lock  = lid_lock_q;
    assign credit    = credit_q;
    assign rinse_sel = rinse_sel_q;
    assign err       = err_q;

endmodule

// File: doc/wm_front_panel.md
# wm_front_panel

Front-panel and payment interface for the washing machine controller: conditions the raw coin, rinse, start and lid-switch inputs and tracks paid credit. When the cycle is paid and the lid is closed, it issues the single-cycle `coin` start pulse and drives the `add_rinse` and `lid_cl` levels into the controller. It then locks the lid until the controller reports `completed`, and sits between the user-facing switches and the controller's inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles before a synchronized input is accepted (min 2).
- `PRICE`, default 3: coins for a standard cycle.
- `RINSE_PRICE`, default 1: extra coins when the extra rinse is selected.
- `CREDIT_MAX`, default 15: credit saturation value (4-bit credit).
- `UNLOCK_DELAY`, default 1000: cycles from `completed` rising to `lid_lock` release.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `coin_sw` in 1: raw coin-acceptor contact, asynchronous, bouncy.
- `rinse_btn` in 1: raw extra-rinse button.
- `start_btn` in 1: raw start button.
- `lid_sw` in 1: raw lid switch, 1 = closed.
- `completed` in 1: controller idle indicator, 1 = idle.
- `coin` out 1: one-cycle start pulse to the controller.
- `add_rinse` out 1: extra-rinse level to the controller.
- `lid_cl` out 1: debounced lid-closed level to the controller.
- `lid_lock` out 1: lid solenoid, 1 = locked.
- `credit` out 4: current credit.
- `rinse_sel` out 1: extra-rinse selection LED.
- `busy` out 1: high in START, RUN and DONE.
- `err` out 1: sticky start-handshake failure flag.

## Operation
- Each raw input passes through a 2-flop synchronizer and then a debounce counter. The counter reloads whenever the synchronized value differs from the accepted value. After `DEBOUNCE_CYCLES` equal cycles, the accepted value updates.
- A debounced rising edge produces a one-cycle internal event (`coin_ev`, `rinse_ev`, `start_ev`). `lid_cl` equals the accepted lid value.
- `cost = PRICE + (rinse_sel ? RINSE_PRICE : 0)`.
- Credit arithmetic is 5-bit internally: `credit_next = min(credit + coin_ev − (launch ? cost : 0), CREDIT_MAX)`. Coins are accepted in every state.
- States:
  - IDLE: `rinse_ev` toggles `rinse_sel`. Go to START when `start_ev && lid_cl && credit >= cost && !err`; otherwise `start_ev` is ignored.
  - START: the `launch` cycle. `coin` = 1, credit is deducted, `lid_lock` is set. Go to ACK.
  - ACK: wait for `completed` = 0, then go to RUN. If `completed` is still 1 after 4 cycles in ACK, set `err`, refund `cost` (saturating), clear `lid_lock`, go to IDLE.
  - RUN: `rinse_ev` is ignored. Go to DONE on `completed` = 1.
  - DONE: count `UNLOCK_DELAY` cycles, then clear `lid_lock`, clear `rinse_sel`, go to IDLE.
- `add_rinse` = `rinse_sel` in START, ACK and RUN, and 0 otherwise.
- `err` clears only on reset.
- Reset, asynchronous at any time, including mid-RUN: state IDLE, credit 0, all outputs 0, accepted input values 0, debounce counters reloaded. Credit is lost.

## Timing
- Raw input change to accepted-value change: 2 + `DEBOUNCE_CYCLES` cycles.
- Accepted rising edge to event: 1 cycle.
- `start_ev` in cycle N → `coin` high in cycle N+1 only, with `lid_lock` and the credit deduction visible in N+2.
- The controller drops `completed` one cycle after `coin`, so ACK normally lasts 1–2 cycles.
- `coin_ev` and launch in the same cycle: both apply, e.g. credit 3 with cost 3 gives 1.
- `rinse_ev` and `start_ev` in the same IDLE cycle: start is evaluated with the old `rinse_sel`, and the toggle is discarded.
- Coin at `CREDIT_MAX`: credit holds at 15.

## Configuration
- `WM_PANEL_REFUND_EN` defined: adds input `refund_btn` and output `refund_pulse`.
  - A debounced `refund_btn` edge in IDLE returns the full credit as `credit` pulses. Each pulse is 1 cycle high, spaced 8 cycles apart, with credit decrementing per pulse.
  - A `coin_ev` at `CREDIT_MAX` emits one `refund_pulse`.
  - Start is blocked while a refund is in progress.
- `WM_PANEL_REFUND_EN` not defined: neither port exists, and excess coins are absorbed.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `UNLOCK_DELAY`=10.
- Bounce `coin_sw` 0/1 every 2 cycles for 20 cycles, then hold it high → `credit` increments exactly once, to 1.
- 3 coins, lid closed, start → `coin` high for exactly 1 cycle, credit 3→0, `lid_lock`=1, `add_rinse`=0. Model `completed` falling, then rising 50 cycles later → `lid_lock` clears 10 cycles after the rise.
- Rinse toggled on, 3 coins, start → no `coin`, credit 3. Add a 4th coin, start → `coin` pulse, credit 0, `add_rinse`=1 throughout RUN.
- Credit 3, lid open, start → no launch. Close the lid, start → launch.
- Tie `completed`=1 and start with credit 3 → `err`=1 after 4 ACK cycles, credit back to 3, `lid_lock`=0, further starts ignored.
- 17 coins → `credit`=15. With `WM_PANEL_REFUND_EN`, 2 `refund_pulse`s. Assert reset mid-RUN → all outputs 0 immediately.
